// File: rtl/traffic_light_monitor_if.sv
// Lamp-drive and status bundle between a traffic light controller and its monitor.
// The master modport is the controller/observer side; the slave modport is the monitor.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic             red;
    logic             yellow;
    logic             green;
    logic             clear_fault;
    logic [1:0]       phase;
    logic             phase_change;
    logic [CNT_W-1:0] dwell;
    logic [15:0]      cycles;
    logic             fault;
    logic [2:0]       fault_code;

    modport master (
        output red, yellow, green, clear_fault,
        input  phase, phase_change, dwell, cycles, fault, fault_code
    );

    modport slave (
        input  red, yellow, green, clear_fault,
        output phase, phase_change, dwell, cycles, fault, fault_code
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Checks lamp drive of a traffic light controller: one-hot lamps, RED->GREEN->YELLOW order,
// per-phase dwell limits, sticky fault code. Define TLM_DWELL_CHECK_EN to enable dwell checks.
module traffic_light_monitor #(
    parameter int CNT_W      = 8,
    parameter int MIN_RED    = 1,
    parameter int MIN_GREEN  = 1,
    parameter int MIN_YELLOW = 1,
    parameter int MAX_DWELL  = 255
) (
    input logic                  clk,
    input logic                  reset,
    traffic_light_monitor_if.slave bus
);

    typedef enum logic [2:0] {
        S_SYNC, S_RED, S_GREEN, S_YELLOW, S_FAULT
    } state_e;

    typedef enum logic [2:0] {
        F_NONE = 3'd0, F_ILLEGAL = 3'd1, F_ORDER = 3'd2, F_SHORT = 3'd3, F_STUCK = 3'd4
    } fault_e;

`ifdef TLM_DWELL_CHECK_EN
    localparam bit DWELL_CHECK = 1'b1;
`else
    localparam bit DWELL_CHECK = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MAX_D   = CNT_W'(MAX_DWELL);

    logic [2:0]       lamp_d, lamp_q;          // {red, yellow, green}
    state_e           state_d, state_q;
    logic [CNT_W-1:0] dwell_d, dwell_q;
    logic [15:0]      cycles_d, cycles_q;
    fault_e           fault_code_d, fault_code_q;
    logic [1:0]       phase_d, phase_q;
    logic             phase_change_d, phase_change_q;
    logic             fault_d, fault_q;

    logic             lamp_valid;
    state_e           lamp_phase;
    state_e           succ;
    logic [CNT_W-1:0] min_cur;
    logic [CNT_W-1:0] dwell_inc;
    logic             short_phase;
    logic             stuck;
    logic             enter;

    assign lamp_d     = {bus.red, bus.yellow, bus.green};
    assign lamp_valid = $onehot(lamp_q);
    assign lamp_phase = (lamp_q == 3'b100) ? S_RED    :
                        (lamp_q == 3'b001) ? S_GREEN  :
                        (lamp_q == 3'b010) ? S_YELLOW : S_SYNC;

    // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_q         <= 3'b000;
            state_q        <= S_SYNC;
            dwell_q        <= '0;
            cycles_q       <= '0;
            fault_code_q   <= F_NONE;
            phase_q        <= 2'b11;
            phase_change_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            lamp_q         <= lamp_d;
            state_q        <= state_d;
            dwell_q        <= dwell_d;
            cycles_q       <= cycles_d;
            fault_code_q   <= fault_code_d;
            phase_q        <= phase_d;
            phase_change_q <= phase_change_d;
            fault_q        <= fault_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        cycles_d     = cycles_q;
        fault_code_d = fault_code_q;
        enter        = 1'b0;
        succ         = S_SYNC;
        min_cur      = '0;
        case (state_q)
            S_RED:    begin succ = S_GREEN;  min_cur = CNT_W'(MIN_RED);    end
            S_GREEN:  begin succ = S_YELLOW; min_cur = CNT_W'(MIN_GREEN);  end
            S_YELLOW: begin succ = S_RED;    min_cur = CNT_W'(MIN_YELLOW); end
            default:  ;
        endcase
        dwell_inc   = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + 1'b1;
        short_phase = DWELL_CHECK && (dwell_q < min_cur);
        stuck       = DWELL_CHECK && (dwell_inc == MAX_D);

        case (state_q)
            S_SYNC: begin
                if (lamp_q != 3'b000 && !lamp_valid) begin
                    state_d      = S_FAULT;
                    fault_code_d = F_ILLEGAL;
                end else if (lamp_valid) begin
                    state_d = lamp_phase;
                    dwell_d = CNT_W'(1);
                    enter   = 1'b1;
                end
            end
            S_FAULT: begin
                if (bus.clear_fault) begin
                    state_d      = S_SYNC;
                    fault_code_d = F_NONE;
                    dwell_d      = '0;
                end
            end
            default: begin
                // Dwell and cycles freeze at their pre-fault values on any fault entry.
                if (!lamp_valid) begin
                    state_d      = S_FAULT;
                    fault_code_d = F_ILLEGAL;
                end else if (lamp_phase == state_q) begin
                    if (stuck) begin
                        state_d      = S_FAULT;
                        fault_code_d = F_STUCK;
                    end else begin
                        dwell_d = dwell_inc;
                    end
                end else if (lamp_phase == succ) begin
                    if (short_phase) begin
                        state_d      = S_FAULT;
                        fault_code_d = F_SHORT;
                    end else begin
                        state_d = lamp_phase;
                        dwell_d = CNT_W'(1);
                        enter   = 1'b1;
                        if (state_q == S_YELLOW) cycles_d = cycles_q + 16'd1;
                    end
                end else begin
                    state_d      = S_FAULT;
                    fault_code_d = F_ORDER;
                end
            end
        endcase
    end

    always_comb begin
        case (state_d)
            S_RED:    phase_d = 2'b00;
            S_GREEN:  phase_d = 2'b01;
            S_YELLOW: phase_d = 2'b10;
            default:  phase_d = 2'b11;
        endcase
        phase_change_d = enter;
        fault_d        = (state_d == S_FAULT);
    end

    assign bus.phase        = phase_q;
    assign bus.phase_change = phase_change_q;
    assign bus.dwell        = dwell_q;
    assign bus.cycles       = cycles_q;
    assign bus.fault        = fault_q;
    assign bus.fault_code   = fault_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: three instances (defaults, MIN_GREEN=3, MAX_DWELL=5)
// share one stimulus; each scenario checks the instance it targets.
module tb_traffic_light_monitor;

`ifdef TLM_DWELL_CHECK_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001, L_OFF = 3'b000;

    logic       clk;
    logic       reset;
    logic [2:0] drv_lamps;
    logic       drv_clr;
    int         sel;
    int         n_checks;
    int         n_fail;

    logic [1:0]  o_phase;
    logic        o_pc;
    logic [7:0]  o_dwell;
    logic [15:0] o_cycles;
    logic        o_fault;
    logic [2:0]  o_code;

    traffic_light_monitor_if #(.CNT_W(8)) if0 ();
    traffic_light_monitor_if #(.CNT_W(8)) if1 ();
    traffic_light_monitor_if #(.CNT_W(8)) if2 ();

    assign {if0.red, if0.yellow, if0.green} = drv_lamps;
    assign {if1.red, if1.yellow, if1.green} = drv_lamps;
    assign {if2.red, if2.yellow, if2.green} = drv_lamps;
    assign if0.clear_fault = drv_clr;
    assign if1.clear_fault = drv_clr;
    assign if2.clear_fault = drv_clr;

    traffic_light_monitor u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    traffic_light_monitor #(.MIN_GREEN(3)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    traffic_light_monitor #(.MAX_DWELL(5)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        o_phase = if0.phase; o_pc = if0.phase_change; o_dwell = if0.dwell;
        o_cycles = if0.cycles; o_fault = if0.fault; o_code = if0.fault_code;
        case (sel)
            1: begin
                o_phase = if1.phase; o_pc = if1.phase_change; o_dwell = if1.dwell;
                o_cycles = if1.cycles; o_fault = if1.fault; o_code = if1.fault_code;
            end
            2: begin
                o_phase = if2.phase; o_pc = if2.phase_change; o_dwell = if2.dwell;
                o_cycles = if2.cycles; o_fault = if2.fault; o_code = if2.fault_code;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] ph, input logic pc, input int dw,
                             input int cy, input logic f, input int fc);
        check({tag, ".phase"},        32'(o_phase),  32'(ph));
        check({tag, ".phase_change"}, 32'(o_pc),     32'(pc));
        check({tag, ".dwell"},        32'(o_dwell),  dw);
        check({tag, ".cycles"},       32'(o_cycles), cy);
        check({tag, ".fault"},        32'(o_fault),  32'(f));
        check({tag, ".fault_code"},   32'(o_code),   fc);
    endtask

    // Drive one cycle of lamps; expectations describe outputs one edge later (lamp_q pipeline).
    task automatic vec(input string tag, input logic [2:0] lamps, input logic clr, input logic [1:0] ph,
                       input logic pc, input int dw, input int cy, input logic f, input int fc);
        drv_lamps = lamps;
        drv_clr   = clr;
        @(posedge clk);
        #1;
        check_all(tag, ph, pc, dw, cy, f, fc);
    endtask

    task automatic do_reset();
        drv_lamps = L_OFF;
        drv_clr   = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 0;
        reset    = 1'b1;
        drv_lamps = L_OFF;
        drv_clr   = 1'b0;

        // 1: legal sequence, one cycle per phase
        do_reset();
        check_all("t1_rst", 2'b11, 0, 0, 0, 0, 0);
        vec("t1_v0", L_R, 0, 2'b11, 0, 0, 0, 0, 0);
        vec("t1_v1", L_G, 0, 2'b00, 1, 1, 0, 0, 0);
        vec("t1_v2", L_Y, 0, 2'b01, 1, 1, 0, 0, 0);
        vec("t1_v3", L_R, 0, 2'b10, 1, 1, 0, 0, 0);
        vec("t1_v4", L_G, 0, 2'b00, 1, 1, 1, 0, 0);
        vec("t1_v5", L_Y, 0, 2'b01, 1, 1, 1, 0, 0);
        vec("t1_v6", L_R, 0, 2'b10, 1, 1, 1, 0, 0);
        vec("t1_v7", L_R, 0, 2'b00, 1, 1, 2, 0, 0);
        vec("t1_v8", L_R, 0, 2'b00, 0, 2, 2, 0, 0);

        // 2: MIN_GREEN=3, green held only 2 cycles
        sel = 1;
        do_reset();
        vec("t2_v0", L_R, 0, 2'b11, 0, 0, 0, 0, 0);
        vec("t2_v1", L_G, 0, 2'b00, 1, 1, 0, 0, 0);
        vec("t2_v2", L_G, 0, 2'b01, 1, 1, 0, 0, 0);
        vec("t2_v3", L_Y, 0, 2'b01, 0, 2, 0, 0, 0);
        vec("t2_v4", L_Y, 0, DWELL_EN ? 2'b11 : 2'b10, !DWELL_EN, DWELL_EN ? 2 : 1, 0, DWELL_EN, DWELL_EN ? 3 : 0);
        vec("t2_v5", L_Y, 0, DWELL_EN ? 2'b11 : 2'b10, 0, 2, 0, DWELL_EN, DWELL_EN ? 3 : 0);

        // 3: skip GREEN, clear, resume; clear outside FAULT ignored
        sel = 0;
        do_reset();
        vec("t3_v0", L_R, 0, 2'b11, 0, 0, 0, 0, 0);
        vec("t3_v1", L_Y, 0, 2'b00, 1, 1, 0, 0, 0);
        vec("t3_v2", L_Y, 0, 2'b11, 0, 1, 0, 1, 2);
        vec("t3_v3", L_R, 1, 2'b11, 0, 0, 0, 0, 0);
        vec("t3_v4", L_R, 0, 2'b00, 1, 1, 0, 0, 0);
        vec("t3_v5", L_R, 1, 2'b00, 0, 2, 0, 0, 0);
        vec("t3_v6", L_R, 0, 2'b00, 0, 3, 0, 0, 0);

        // 4: multi-lamp in RED, then dark lamps in SYNC
        do_reset();
        vec("t4_v0", L_R,    0, 2'b11, 0, 0, 0, 0, 0);
        vec("t4_v1", 3'b101, 0, 2'b00, 1, 1, 0, 0, 0);
        vec("t4_v2", L_OFF,  0, 2'b11, 0, 1, 0, 1, 1);
        vec("t4_v3", L_OFF,  1, 2'b11, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            vec($sformatf("t4_dark%0d", i), L_OFF, 0, 2'b11, 0, 0, 0, 0, 0);

        // 5: MAX_DWELL=5, hold RED
        sel = 2;
        do_reset();
        vec("t5_v0", L_R, 0, 2'b11, 0, 0, 0, 0, 0);
        vec("t5_v1", L_R, 0, 2'b00, 1, 1, 0, 0, 0);
        vec("t5_v2", L_R, 0, 2'b00, 0, 2, 0, 0, 0);
        vec("t5_v3", L_R, 0, 2'b00, 0, 3, 0, 0, 0);
        vec("t5_v4", L_R, 0, 2'b00, 0, 4, 0, 0, 0);
        vec("t5_v5", L_R, 0, DWELL_EN ? 2'b11 : 2'b00, 0, DWELL_EN ? 4 : 5, 0, DWELL_EN, DWELL_EN ? 4 : 0);
        repeat (249) @(posedge clk);
        vec("t5_sat", L_R, 0, DWELL_EN ? 2'b11 : 2'b00, 0, DWELL_EN ? 4 : 255, 0, DWELL_EN, DWELL_EN ? 4 : 0);
        vec("t5_hold", L_R, 0, DWELL_EN ? 2'b11 : 2'b00, 0, DWELL_EN ? 4 : 255, 0, DWELL_EN, DWELL_EN ? 4 : 0);

        // 6: async reset mid-GREEN with dwell=7, cycles=3
        sel = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drv_lamps = L_R; @(posedge clk); #1;
            drv_lamps = L_G; @(posedge clk); #1;
            drv_lamps = L_Y; @(posedge clk); #1;
        end
        drv_lamps = L_R; @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            drv_lamps = L_G; @(posedge clk); #1;
        end
        vec("t6_pre", L_G, 0, 2'b01, 0, 7, 3, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_all("t6_async", 2'b11, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
